// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N-channel event counters with halt gating, wrap/saturate, sticky overflow, registered read; PERF_SNAPSHOT_EN adds a snapshot bank
module perf_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int SEL_W = 2,
  parameter bit SAT = 1'b0,
  parameter logic [NUM_CH-1:0] HALT_MASK = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              go,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              clr,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_snap,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic gate;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt, rd_src;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (halt & ~go) ? HALTED : RUN;
    gate = (state == HALTED) & halt & ~go;
    inc = event_in & ~({NUM_CH{gate}} & HALT_MASK);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ovf <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (clr) begin
          cnt[k] <= '0;
          ovf[k] <= 1'b0;
        end else if (inc[k]) begin
          cnt[k] <= (SAT && (&cnt[k])) ? cnt[k] : cnt[k] + 1'b1;
          ovf[k] <= ovf[k] | (&cnt[k]);
        end
    end
`ifdef PERF_SNAPSHOT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] snap_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) snap_q <= '0;
    else if (snap) snap_q <= cnt;
  assign rd_src = rd_snap ? snap_q : cnt;
`else
  logic unused_snap;
  assign unused_snap = snap ^ rd_snap;
  assign rd_src = cnt;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= (32'(rd_sel) < NUM_CH) ? rd_src[rd_sel] : '0;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: three 8-bit banks (wrap, saturate, 3-channel) against a behavioural model
module tb_perf_counter_bank;
`ifdef PERF_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, halt = 1'b0, go = 1'b0, clr = 1'b0, snap = 1'b0, rd_snap = 1'b0;
  logic [3:0] ev = '0;
  logic [1:0] rd_sel = '0;
  logic [7:0] rd_a, rd_b, rd_c;
  logic [3:0] ovf_a, ovf_b;
  logic [2:0] ovf_c;
  int checks = 0, fails = 0;
  int unsigned m_cnt [3][4];
  int unsigned m_snap [3][4];
  bit m_ovf [3][4];
  int unsigned m_rd [3];
  bit m_halted;
  always #5 clk = ~clk;
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SEL_W(2), .SAT(1'b0), .HALT_MASK(4'b0111)) dut_a (
    .clk(clk), .rst(rst), .halt(halt), .go(go), .event_in(ev), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_snap(rd_snap), .rd_data(rd_a), .ovf(ovf_a));
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SEL_W(2), .SAT(1'b1), .HALT_MASK(4'b0111)) dut_b (
    .clk(clk), .rst(rst), .halt(halt), .go(go), .event_in(ev), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_snap(rd_snap), .rd_data(rd_b), .ovf(ovf_b));
  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SEL_W(2), .SAT(1'b0), .HALT_MASK(3'b101)) dut_c (
    .clk(clk), .rst(rst), .halt(halt), .go(go), .event_in(ev[2:0]), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_snap(rd_snap), .rd_data(rd_c), .ovf(ovf_c));
  function automatic int nch(int d);
    return (d == 2) ? 3 : 4;
  endfunction
  function automatic bit frozen(int d, int i);
    logic [3:0] m;
    m = (d == 2) ? 4'b0101 : 4'b0111;
    return m[i];
  endfunction
  task automatic chk(string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_rd[d] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0;
        m_snap[d][i] = 0;
        m_ovf[d][i] = 1'b0;
      end
    end
    m_halted = 1'b0;
  endtask
  task automatic model_update();
    bit gate;
    gate = m_halted && halt && !go;
    for (int d = 0; d < 3; d++) begin
      m_rd[d] = (int'(rd_sel) < nch(d)) ?
                ((SNAP_EN && rd_snap) ? m_snap[d][rd_sel] : m_cnt[d][rd_sel]) : 0;
      for (int i = 0; i < nch(d); i++) begin
        if (SNAP_EN && snap) m_snap[d][i] = m_cnt[d][i];
        if (clr) begin
          m_cnt[d][i] = 0;
          m_ovf[d][i] = 1'b0;
        end else if (ev[i] && !(gate && frozen(d, i))) begin
          if (m_cnt[d][i] == 255) begin
            m_ovf[d][i] = 1'b1;
            m_cnt[d][i] = (d == 1) ? 255 : 0;
          end else m_cnt[d][i] = m_cnt[d][i] + 1;
        end
      end
    end
    m_halted = halt && !go;
  endtask
  task automatic check_all();
    logic [3:0] eo [3];
    for (int d = 0; d < 3; d++) begin
      eo[d] = '0;
      for (int i = 0; i < nch(d); i++) eo[d][i] = m_ovf[d][i];
    end
    chk("rd_a", rd_a, m_rd[0]);
    chk("rd_b", rd_b, m_rd[1]);
    chk("rd_c", rd_c, m_rd[2]);
    chk("ovf_a", ovf_a, eo[0]);
    chk("ovf_b", ovf_b, eo[1]);
    chk("ovf_c", ovf_c, eo[2]);
  endtask
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_a", rd_a, 0);
    chk("reset_ovf_a", ovf_a, 0);
    rst = 1'b0;
    ev = 4'b0001;
    repeat (17) tick();
    ev = '0;
    rd_sel = 2'd0;
    tick();
    chk("pre_rst_ch0", rd_a, 17);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_a", rd_a, 0);
    chk("async_rst_ovf_a", ovf_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    ev = 4'b0101;
    rd_sel = 2'd2;
    repeat (10) tick();
    ev = '0;
    tick();
    chk("ch2_ten", rd_a, 10);
    halt = 1'b1;
    tick();
    ev = 4'b1111;
    repeat (5) tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    halt = 1'b0;
    ev = '0;
    rd_sel = 2'd3;
    tick();
    chk("ch3_unmasked", rd_a, 6);
    rd_sel = 2'd0;
    tick();
    chk("ch0_go_step", rd_a, 11);
    ev = 4'b0010;
    repeat (254) tick();
    tick();
    ev = '0;
    rd_sel = 2'd1;
    tick();
    chk("wrap_ch1", rd_a, 0);
    chk("sat_ch1", rd_b, 255);
    chk("wrap_ovf1", ovf_a[1], 1);
    chk("sat_ovf1", ovf_b[1], 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("clr_ovf_b", ovf_b, 0);
    chk("clr_ch1_b", rd_b, 0);
    ev = 4'b0001;
    repeat (42) tick();
    snap = 1'b1;
    clr = 1'b1;
    tick();
    snap = 1'b0;
    clr = 1'b0;
    ev = '0;
    rd_sel = 2'd0;
    rd_snap = 1'b1;
    tick();
    chk("snap_read", rd_a, SNAP_EN ? 42 : 0);
    rd_snap = 1'b0;
    tick();
    chk("live_after_clr", rd_a, 0);
    rd_sel = 2'd3;
    tick();
    chk("oob_sel", rd_c, 0);
    repeat (800) begin
      ev = 4'($urandom);
      halt = $urandom_range(1, 0) == 1;
      go = $urandom_range(4, 0) == 0;
      clr = $urandom_range(399, 0) == 0;
      snap = $urandom_range(5, 0) == 0;
      rd_sel = 2'($urandom);
      rd_snap = $urandom_range(1, 0) == 1;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("final_rst_rd_b", rd_b, 0);
    chk("final_rst_ovf_b", ovf_b, 0);
    chk("final_rst_ovf_c", ovf_c, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
